ps2_scancode_rx: RTL and testbench

// - Receives PS/2 set-2 keyboard frames and packs each key event into the 11-bit ps2_key word.
// - ps2_key drives the keyboard matrix stage (keyboard_for_ace), which maps it onto the 8 rows x 5 columns.
// - Runs in the same clock domain as the keyboard matrix (CPU clock).
// - Samples the device-driven PS/2 clock and data lines. Receive only: the block never drives the bus.

---
 rtl/ps2_scancode_rx.sv | 220 ++++++++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx
// Receives PS/2 set-2 keyboard frames, which have 11 bits each: start, 8 data
// bits LSB first, odd parity and stop. Each frame is sampled on a filtered
// falling edge of ps2_clk. Accepted bytes go through a small prefix decoder
// (E0 extended, F0 break, E1 Pause skip, device responses dropped). Each key
// event is packed into the 11-bit ps2_key word.
// The block only receives and never drives the PS/2 bus.
//
// Ports
//   clk        system clock (same domain as the keyboard matrix)
//   reset      asynchronous, active-low reset
//   ps2_clk    raw PS/2 clock from the device (asynchronous)
//   ps2_data   raw PS/2 data from the device (asynchronous)
//   ps2_key    [10] event toggle, [9] 1=make/0=break, [8] E0-extended,
//              [7:0] scancode
//   frame_err  one-cycle pulse on a start, parity, stop or timeout error
module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Input synchronisers: index 0 = clock line, index 1 = data line.
  logic [1:0] raw_in;
  logic [1:0] sync_s1_reg;
  logic [1:0] sync_s2_reg;

  assign raw_in = {ps2_data, ps2_clk};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync_s1_reg[gi] <= 1'b1;
          sync_s2_reg[gi] <= 1'b1;
        end else begin
          sync_s1_reg[gi] <= raw_in[gi];
          sync_s2_reg[gi] <= sync_s1_reg[gi];
        end
      end
    end
  endgenerate

  logic ps2_clk_sync;
  logic ps2_data_sync;
  assign ps2_clk_sync  = sync_s2_reg[0];
  assign ps2_data_sync = sync_s2_reg[1];

  // Glitch filter. The counter restarts on any change of the synced clock.
  // The filtered clock only follows the synced clock after the level has
  // been held for FILTER_LEN cycles, so short glitches never reach the FSM.
  logic          clk_prev_reg;
  logic [FW-1:0] filt_cnt_reg;
  logic          fclk_reg;
  logic          fall_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_prev_reg <= 1'b1;
      filt_cnt_reg <= '0;
      fclk_reg     <= 1'b1;
      fall_reg     <= 1'b0;
    end else begin
      clk_prev_reg <= ps2_clk_sync;
      fall_reg     <= 1'b0;
      if (ps2_clk_sync != clk_prev_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg != FILT_MAX) begin
        filt_cnt_reg <= filt_cnt_reg + 1'b1;
      end else begin
        fclk_reg <= ps2_clk_sync;
        fall_reg <= fclk_reg & ~ps2_clk_sync;
      end
    end
  end

  // Frame FSM
  state_t        state_reg, state_next;
  logic [2:0]    bitcnt_reg, bitcnt_next;
  logic [7:0]    sh_reg, sh_next;
  logic          par_ok_reg, par_ok_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          accept_reg, accept_next;
  logic          err_reg, err_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      bitcnt_reg <= '0;
      sh_reg     <= '0;
      par_ok_reg <= 1'b0;
      timer_reg  <= '0;
      accept_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      bitcnt_reg <= bitcnt_next;
      sh_reg     <= sh_next;
      par_ok_reg <= par_ok_next;
      timer_reg  <= timer_next;
      accept_reg <= accept_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    bitcnt_next = bitcnt_reg;
    sh_next     = sh_reg;
    par_ok_next = par_ok_reg;
    accept_next = 1'b0;
    err_next    = 1'b0;
    // The timer measures cycles since the last fall while a frame is open.
    timer_next  = (state_reg == IDLE || fall_reg) ? '0 : timer_reg + 1'b1;

    case (state_reg)
      IDLE: begin
        if (fall_reg) begin
          if (!ps2_data_sync) begin
            state_next  = DATA;
            bitcnt_next = '0;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      DATA: begin
        if (fall_reg) begin
          sh_next     = {ps2_data_sync, sh_reg[7:1]};
          bitcnt_next = bitcnt_reg + 1'b1;
          if (bitcnt_reg == 3'd7) state_next = PARITY;
        end
      end
      PARITY: begin
        if (fall_reg) begin
          par_ok_next = ^{sh_reg, ps2_data_sync};
          state_next  = STOP;
        end
      end
      STOP: begin
        if (fall_reg) begin
          if (ps2_data_sync && par_ok_reg) accept_next = 1'b1;
          else                             err_next    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // A fall in the same cycle takes priority over expiry.
    if (state_reg != IDLE && !fall_reg && timer_reg == TMO_MAX) begin
      state_next = IDLE;
      err_next   = 1'b1;
    end
  end

  assign frame_err = err_reg;

  // Byte decoder. sh_reg still holds the accepted byte one cycle after the
  // stop bit, because the next shift only happens after a new start bit.
  logic       ext_reg;
  logic       brk_reg;
  logic [2:0] skip_cnt_reg;
  logic [10:0] key_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ext_reg      <= 1'b0;
      brk_reg      <= 1'b0;
      skip_cnt_reg <= '0;
      key_reg      <= '0;
    end else if (accept_reg) begin
      if (skip_cnt_reg != 3'd0) begin
        // Bytes that follow E1 belong to the Pause sequence.
        skip_cnt_reg <= skip_cnt_reg - 1'b1;
      end else begin
        case (sh_reg)
          8'hE1: begin
            skip_cnt_reg <= 3'd7;
            ext_reg      <= 1'b0;
            brk_reg      <= 1'b0;
          end
          8'hE0: ext_reg <= 1'b1;
          8'hF0: brk_reg <= 1'b1;
          8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: begin
            ext_reg <= 1'b0;
            brk_reg <= 1'b0;
          end
          default: begin
            key_reg <= {~key_reg[10], ~brk_reg, ext_reg, sh_reg};
            ext_reg <= 1'b0;
            brk_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ps2_key = key_reg;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
module tb_ps2_scancode_rx;

  localparam int TMO  = 16384;
  localparam int HALF = 20;   // PS/2 clock half period in clk cycles

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;

  ps2_scancode_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ps2_key   (ps2_key),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    bit          tmo;
    logic [10:0] key;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   last_fall_cyc = 0;

  // Reference model: a key-event interpreter working on the received byte stream.
  bit          m_tog, m_ext, m_brk;
  int          m_skip;
  logic [10:0] m_last;

  task automatic model_reset();
    m_tog = 0; m_ext = 0; m_brk = 0; m_skip = 0; m_last = '0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    exp_t e;
    if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hE1) begin
      m_skip = 7; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF}) begin
      m_ext = 0; m_brk = 0;
    end else begin
      m_tog  = !m_tog;
      m_last = {m_tog, !m_brk, m_ext, b};
      e.is_err = 0; e.tmo = 0; e.key = m_last;
      q.push_back(e);
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic push_err(input bit tmo);
    exp_t e;
    e.is_err = 1; e.tmo = tmo; e.key = '0;
    q.push_back(e);
  endtask

  // Drive bits [0 .. nbits-1] of a frame; each bit has a fall mid-way.
  task automatic drive_bits(input logic [10:0] bits, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (HALF/2) @(posedge clk);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
      if (glitch) begin
        repeat (4) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (HALF/2 - 7) @(posedge clk);
      end else begin
        repeat (HALF/2) @(posedge clk);
      end
    end
    ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] f;
    f[0]   = 1'b0;
    f[8:1] = b;
    f[9]   = (~^b) ^ bad_par;
    f[10]  = ~bad_stop;
    return f;
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
    if (bad_par || bad_stop) push_err(0);
    else                     model_byte(b);
    drive_bits(frame_bits(b, bad_par, bad_stop), 11, glitch);
  endtask

  task automatic check_now(input string name, input logic [10:0] act, input logic [10:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%03h required 0x%03h", name, act, req);
    end else begin
      $display("ok   %s: 0x%03h", name, act);
    end
  endtask

  task automatic expect_key(input string name, input logic [10:0] req);
    repeat (20) @(posedge clk);
    #1;
    check_now(name, ps2_key, req);
  endtask

  // Monitor: pops an expectation for every ps2_key change and every frame_err.
  logic [10:0] mon_last = '0;

  task automatic check_out(input bit is_err, input logic [10:0] key);
    exp_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_output: got err=%0d key=0x%03h required nothing", is_err, key);
      return;
    end
    e = q.pop_front();
    if (e.is_err != is_err || (!is_err && e.key !== key)) begin
      n_bad++;
      $display("FAIL scoreboard: got err=%0d key=0x%03h required err=%0d key=0x%03h",
               is_err, key, e.is_err, e.key);
    end else begin
      $display("ok   scoreboard: err=%0d key=0x%03h", is_err, key);
    end
    if (e.tmo) begin
      n_cmp++;
      if (!is_err || (cyc - last_fall_cyc) < TMO || (cyc - last_fall_cyc) > TMO + 25) begin
        n_bad++;
        $display("FAIL timeout_delay: got %0d cycles required %0d..%0d",
                 cyc - last_fall_cyc, TMO, TMO + 25);
      end else begin
        $display("ok   timeout_delay: %0d cycles", cyc - last_fall_cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon_last = '0;
    end else begin
      if (ps2_key !== mon_last) begin
        check_out(1'b0, ps2_key);
        mon_last = ps2_key;
      end
      if (frame_err === 1'b1) check_out(1'b1, '0);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  logic [7:0] resp_codes [7] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
  logic [7:0] pause_seq  [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

  initial begin
    int r;
    logic [7:0] b;
    bit bp, bs;
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    check_now("reset_key", ps2_key, 11'h000);
    check_now("reset_err", {10'd0, frame_err}, 11'h000);
    @(posedge clk);
    reset = 1'b1;
    repeat (10) @(posedge clk);

    // Directed cases; bit 9 is set for make codes.
    send_frame(8'h1C, 0, 0, 0);  expect_key("make_1C", 11'h61C);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h1C, 0, 0, 0);  expect_key("break_1C", 11'h01C);
    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'h75, 0, 0, 0);  expect_key("ext_75", 11'h775);
    send_frame(8'h1C, 1, 0, 0);  expect_key("bad_parity_hold", 11'h775);
    send_frame(8'h29, 0, 0, 0);  expect_key("after_parity_29", 11'h229);

    // Start bit seen as 1 in IDLE.
    push_err(0);
    ps2_data = 1'b1;
    ps2_clk = 1'b0; repeat (HALF) @(posedge clk);
    ps2_clk = 1'b1; repeat (HALF) @(posedge clk);

    // Timeout after start + 5 data bits.
    push_err(1);
    drive_bits(frame_bits(8'h5A, 0, 0), 6, 0);
    repeat (20000) @(posedge clk);
    send_frame(8'h1C, 0, 0, 0);  expect_key("after_timeout", 11'h61C);

    // Pause sequence, then one real key.
    for (int i = 0; i < 8; i++) send_frame(pause_seq[i], 0, 0, 0);
    expect_key("pause_no_event", 11'h61C);
    send_frame(8'h5A, 0, 0, 0);  expect_key("after_pause_5A", 11'h25A);

    // Short glitch in IDLE.
    ps2_clk = 1'b0; repeat (3) @(posedge clk);
    ps2_clk = 1'b1; repeat (40) @(posedge clk);
    #1;
    check_now("glitch_idle", ps2_key, 11'h25A);

    // Reset mid-DATA.
    send_frame(8'hE0, 0, 0, 0);
    drive_bits(frame_bits(8'h33, 0, 0), 4, 0);
    @(posedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_now("midreset_key", ps2_key, 11'h000);
    check_now("midreset_err", {10'd0, frame_err}, 11'h000);
    model_reset();
    @(posedge clk);
    reset = 1'b1;
    repeat (10) @(posedge clk);
    send_frame(8'h1C, 0, 0, 0);  expect_key("after_reset_1C", 11'h61C);

    // Randomized traffic.
    for (int n = 0; n < 50; n++) begin
      r = $urandom_range(0, 99);
      if      (r < 10) b = 8'hE0;
      else if (r < 22) b = 8'hF0;
      else if (r < 25) b = 8'hE1;
      else if (r < 32) b = resp_codes[$urandom_range(0, 6)];
      else             b = 8'($urandom);
      r  = $urandom_range(0, 99);
      bp = (r < 8);
      bs = (r >= 8 && r < 13);
      send_frame(b, bp, bs, ($urandom_range(0, 2) == 0));
    end

    for (int w = 0; w < 500 && q.size() != 0; w++) @(posedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end else begin
      $display("ok   drain: scoreboard empty");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
